// File: rtl/si_shoot_controller_pkg.sv
// Shared constants and types for the player-bullet path (shooter, shift register, collision).
package si_shoot_pkg;
   localparam int ROWS  = 7;
   localparam int WIDTH = 8;
   localparam int COL_W = $clog2(WIDTH);
   localparam int ROW_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_FLIGHT = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] col_onehot(input logic [COL_W-1:0] col);
      col_onehot = WIDTH'(1) << col;
   endfunction
endpackage

// File: rtl/si_shoot_controller_if.sv
// Bundle between the game core (master) and the shoot controller (slave).
interface si_shoot_controller_if;
   import si_shoot_pkg::*;

   logic                 SHOOT_CTRL_Enable_InHigh;
   logic                 SHOOT_CTRL_Fire_InLow;
   logic [COL_W-1:0]     SHOOT_CTRL_PlayerCol_InBus;
   logic                 SHOOT_CTRL_Hit_InHigh;
   logic                 SHOOT_CTRL_Load_OutLow;
   logic                 SHOOT_CTRL_Clear_OutLow;
   logic [WIDTH-1:0]     SHOOT_CTRL_Data_OutBus;
   logic                 SHOOT_CTRL_Busy_OutHigh;
   logic [ROW_W-1:0]     SHOOT_CTRL_Row_OutBus;

   modport master (
      output SHOOT_CTRL_Enable_InHigh, SHOOT_CTRL_Fire_InLow,
             SHOOT_CTRL_PlayerCol_InBus, SHOOT_CTRL_Hit_InHigh,
      input  SHOOT_CTRL_Load_OutLow, SHOOT_CTRL_Clear_OutLow,
             SHOOT_CTRL_Data_OutBus, SHOOT_CTRL_Busy_OutHigh, SHOOT_CTRL_Row_OutBus
   );

   modport slave (
      input  SHOOT_CTRL_Enable_InHigh, SHOOT_CTRL_Fire_InLow,
             SHOOT_CTRL_PlayerCol_InBus, SHOOT_CTRL_Hit_InHigh,
      output SHOOT_CTRL_Load_OutLow, SHOOT_CTRL_Clear_OutLow,
             SHOOT_CTRL_Data_OutBus, SHOOT_CTRL_Busy_OutHigh, SHOOT_CTRL_Row_OutBus
   );
endinterface

// File: rtl/si_tick_divider.sv
// Enable-gated modulo-TICK_DIV counter; tick is high for the one cycle the count sits at TICK_DIV-1.
module si_tick_divider #(
   parameter int TICK_DIV = 2_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] r_count;
   logic             w_at_end;

   assign w_at_end = (r_count == CNT_W'(TICK_DIV - 1));
   assign tick     = en & w_at_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (en) begin
         if (w_at_end) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end
      end else begin
         r_count <= r_count;
      end
   end
endmodule

// File: rtl/si_shoot_controller.sv
// Fire button to bullet shift-register driver: one bullet in flight, registered active-low strobes.
module si_shoot_controller
   import si_shoot_pkg::*;
#(
   parameter int TICK_DIV = 2_500_000
) (
   input  logic                  SHOOT_CTRL_CLOCK_50,
   input  logic                  SHOOT_CTRL_RESET_InHigh,
   si_shoot_controller_if.slave  bus
);
   logic             w_tick;
   logic             w_fire_fall;
   logic             w_en;
   logic [COL_W-1:0] w_col;

   logic             r_sync1, r_sync2, r_sync_prev;
   state_t           r_state;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             r_busy, r_load, r_clear;
   logic [WIDTH-1:0] r_data;

   si_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (SHOOT_CTRL_CLOCK_50),
      .rst  (SHOOT_CTRL_RESET_InHigh),
      .en   (w_en),
      .tick (w_tick)
   );

   assign w_en        = bus.SHOOT_CTRL_Enable_InHigh;
   assign w_col       = bus.SHOOT_CTRL_PlayerCol_InBus[COL_W-1:0];
   assign w_fire_fall = r_sync_prev & ~r_sync2;

   always_ff @(posedge SHOOT_CTRL_CLOCK_50) begin
      if (SHOOT_CTRL_RESET_InHigh) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_sync_prev <= 1'b1;
      end else begin
         r_sync1     <= bus.SHOOT_CTRL_Fire_InLow;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
      end
   end

   // Strobes default high each cycle so any low pulse lasts exactly one clock.
   always_ff @(posedge SHOOT_CTRL_CLOCK_50) begin
      if (SHOOT_CTRL_RESET_InHigh) begin
         r_state <= ST_IDLE;
         r_col   <= '0;
         r_row   <= '0;
         r_busy  <= 1'b0;
         r_load  <= 1'b1;
         r_clear <= 1'b1;
         r_data  <= '0;
      end else begin
         r_load  <= 1'b1;
         r_clear <= 1'b1;
         r_data  <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_fire_fall && w_en) begin
                  r_col   <= w_col;
                  r_busy  <= 1'b1;
                  r_state <= ST_ARMED;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ARMED: begin
               if (!w_en) begin
                  r_clear <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_tick) begin
                  r_load  <= 1'b0;
                  r_data  <= col_onehot(r_col);
                  r_row   <= ROW_W'(1);
                  r_state <= ST_FLIGHT;
               end else begin
                  r_state <= ST_ARMED;
               end
            end
            ST_FLIGHT: begin
               // Abort and hit both beat a coincident tick: clear only, never a shift.
               if (!w_en || bus.SHOOT_CTRL_Hit_InHigh) begin
                  r_clear <= 1'b0;
                  r_row   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_tick) begin
                  r_load <= 1'b0;
                  if (r_row == ROW_W'(ROWS)) begin
                     r_row   <= '0;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_row   <= r_row + ROW_W'(1);
                     r_state <= ST_FLIGHT;
                  end
               end else begin
                  r_state <= ST_FLIGHT;
               end
            end
            default: begin
               r_row   <= '0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.SHOOT_CTRL_Load_OutLow  = r_load;
   assign bus.SHOOT_CTRL_Clear_OutLow = r_clear;
   assign bus.SHOOT_CTRL_Data_OutBus  = r_data;
   assign bus.SHOOT_CTRL_Busy_OutHigh = r_busy;
   assign bus.SHOOT_CTRL_Row_OutBus   = r_row;
endmodule

// File: tb/tb_si_shoot_controller.sv
// Directed bench for si_shoot_controller with TICK_DIV=4 and a 7-row shift-register model.
module tb_si_shoot_controller;
   import si_shoot_pkg::*;

   localparam int TICK_DIV = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   si_shoot_controller_if bus();

   si_shoot_controller #(.TICK_DIV(TICK_DIV)) dut (
      .SHOOT_CTRL_CLOCK_50     (clk),
      .SHOOT_CTRL_RESET_InHigh (rst),
      .bus                     (bus)
   );

   typedef struct {
      logic       rst, en, fire_n, hit;
      logic [2:0] col;
      logic       exp_load, exp_clear;
      logic [7:0] exp_data;
      logic       exp_busy;
      logic [2:0] exp_row;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int n_load, n_clear, n_launch, n_fila7;
   logic [7:0] fila [1:7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clr_counts();
      n_load = 0; n_clear = 0; n_launch = 0; n_fila7 = 0;
   endtask

   // One clock; sample at negedge, update register model and event counters.
   task automatic step();
      logic l, c;
      logic [7:0] d;
      int pos;
      @(posedge clk);
      @(negedge clk);
      l = bus.SHOOT_CTRL_Load_OutLow;
      c = bus.SHOOT_CTRL_Clear_OutLow;
      d = bus.SHOOT_CTRL_Data_OutBus;
      check("strobe_rules", {30'd0, (!l && !c), (d != 8'd0 && l)}, 32'd0);
      if (!l) n_load++;
      if (!c) n_clear++;
      if (d != 8'd0) n_launch++;
      if (rst || !c) begin
         for (int i = 1; i <= 7; i++) fila[i] = 8'd0;
      end else if (!l) begin
         for (int i = 7; i > 1; i--) fila[i] = fila[i-1];
         fila[1] = d;
      end
      if (!l && !rst) begin
         pos = 0;
         for (int i = 1; i <= 7; i++) if (fila[i] != 8'd0) pos = i;
         check("row_align", 32'(bus.SHOOT_CTRL_Row_OutBus), 32'(pos));
         if (fila[7][5]) n_fila7++;
      end
   endtask

   task automatic wait_row(input int r, input int budget, input string name);
      int n = 0;
      while (int'(bus.SHOOT_CTRL_Row_OutBus) != r && n < budget) begin step(); n++; end
      check(name, 32'(bus.SHOOT_CTRL_Row_OutBus), 32'(r));
   endtask

   task automatic wait_busy(input logic b, input int budget, input string name);
      int n = 0;
      while (bus.SHOOT_CTRL_Busy_OutHigh !== b && n < budget) begin step(); n++; end
      check(name, 32'(bus.SHOOT_CTRL_Busy_OutHigh), 32'(b));
   endtask

   task automatic press(input logic [2:0] col, input string name);
      bus.SHOOT_CTRL_PlayerCol_InBus = col;
      bus.SHOOT_CTRL_Fire_InLow = 1'b0;
      wait_busy(1'b1, 5, name);
      bus.SHOOT_CTRL_Fire_InLow = 1'b1;
   endtask

   vec_t vecs [12];

   initial begin
      int c0, n;
      for (int i = 1; i <= 7; i++) fila[i] = 8'd0;
      clr_counts();
      //             rst   en    fire  hit   col   load  clr   data    busy  row
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b1, 3'd0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 8'h20, 1'b1, 3'd1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b1, 3'd1};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b1, 3'd1};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b1, 3'd1};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 8'h00, 1'b1, 3'd2};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b1, 3'd2};

      // Reset and the first launch, cycle by cycle.
      for (int i = 0; i < 12; i++) begin
         rst = vecs[i].rst;
         bus.SHOOT_CTRL_Enable_InHigh   = vecs[i].en;
         bus.SHOOT_CTRL_Fire_InLow      = vecs[i].fire_n;
         bus.SHOOT_CTRL_Hit_InHigh      = vecs[i].hit;
         bus.SHOOT_CTRL_PlayerCol_InBus = vecs[i].col;
         step();
         check($sformatf("vec%0d_load", i),  32'(bus.SHOOT_CTRL_Load_OutLow),  32'(vecs[i].exp_load));
         check($sformatf("vec%0d_clear", i), 32'(bus.SHOOT_CTRL_Clear_OutLow), 32'(vecs[i].exp_clear));
         check($sformatf("vec%0d_data", i),  32'(bus.SHOOT_CTRL_Data_OutBus),  32'(vecs[i].exp_data));
         check($sformatf("vec%0d_busy", i),  32'(bus.SHOOT_CTRL_Busy_OutHigh), 32'(vecs[i].exp_busy));
         check($sformatf("vec%0d_row", i),   32'(bus.SHOOT_CTRL_Row_OutBus),   32'(vecs[i].exp_row));
      end
      bus.SHOOT_CTRL_Fire_InLow = 1'b1;
      wait_busy(1'b0, 60, "flight_end_busy");
      check("flight_end_row", 32'(bus.SHOOT_CTRL_Row_OutBus), 32'd0);
      check("flight_loads", 32'(n_load), 32'd8);
      check("flight_launches", 32'(n_launch), 32'd1);
      check("fila7_bit5_steps", 32'(n_fila7), 32'd1);
      repeat (3) step();

      // Hit coincident with a tick at row 3.
      press(3'd2, "hit_arm");
      wait_row(3, 40, "hit_reach_row3");
      n = 0;
      while (dut.u_tick.r_count != 2'(TICK_DIV - 1) && n < 8) begin step(); n++; end
      check("hit_tick_align", 32'(dut.u_tick.r_count), 32'(TICK_DIV - 1));
      clr_counts();
      bus.SHOOT_CTRL_Hit_InHigh = 1'b1;
      step();
      bus.SHOOT_CTRL_Hit_InHigh = 1'b0;
      check("hit_clear", 32'(bus.SHOOT_CTRL_Clear_OutLow), 32'd0);
      check("hit_no_load", 32'(bus.SHOOT_CTRL_Load_OutLow), 32'd1);
      check("hit_row", 32'(bus.SHOOT_CTRL_Row_OutBus), 32'd0);
      check("hit_busy", 32'(bus.SHOOT_CTRL_Busy_OutHigh), 32'd0);
      repeat (12) step();
      bus.SHOOT_CTRL_Hit_InHigh = 1'b1;
      repeat (3) step();
      bus.SHOOT_CTRL_Hit_InHigh = 1'b0;
      check("after_hit_loads", 32'(n_load), 32'd0);
      check("after_hit_clears", 32'(n_clear), 32'd1);

      // Button held 100 cycles: a single shot.
      clr_counts();
      bus.SHOOT_CTRL_PlayerCol_InBus = 3'd1;
      bus.SHOOT_CTRL_Fire_InLow = 1'b0;
      repeat (100) step();
      bus.SHOOT_CTRL_Fire_InLow = 1'b1;
      check("hold_launches", 32'(n_launch), 32'd1);
      check("hold_loads", 32'(n_load), 32'd8);
      check("hold_busy", 32'(bus.SHOOT_CTRL_Busy_OutHigh), 32'd0);
      repeat (3) step();

      // Second press during flight is dropped.
      clr_counts();
      press(3'd6, "repress_arm");
      wait_row(3, 40, "repress_row3");
      bus.SHOOT_CTRL_Fire_InLow = 1'b0;
      repeat (6) step();
      bus.SHOOT_CTRL_Fire_InLow = 1'b1;
      wait_busy(1'b0, 60, "repress_end");
      repeat (20) step();
      check("repress_launches", 32'(n_launch), 32'd1);
      check("repress_loads", 32'(n_load), 32'd8);

      // Enable dropped at row 4: one clear, frozen tick counter.
      press(3'd7, "en_arm");
      wait_row(4, 40, "en_row4");
      clr_counts();
      bus.SHOOT_CTRL_Enable_InHigh = 1'b0;
      step();
      check("en_clear", 32'(bus.SHOOT_CTRL_Clear_OutLow), 32'd0);
      check("en_no_load", 32'(bus.SHOOT_CTRL_Load_OutLow), 32'd1);
      check("en_row", 32'(bus.SHOOT_CTRL_Row_OutBus), 32'd0);
      check("en_busy", 32'(bus.SHOOT_CTRL_Busy_OutHigh), 32'd0);
      c0 = int'(dut.u_tick.r_count);
      repeat (10) step();
      check("en_frozen", 32'(dut.u_tick.r_count), 32'(c0));
      check("en_clears", 32'(n_clear), 32'd1);
      check("en_loads", 32'(n_load), 32'd0);
      bus.SHOOT_CTRL_Enable_InHigh = 1'b1;
      step();
      step();
      check("en_resume", 32'(dut.u_tick.r_count), 32'((c0 + 2) % TICK_DIV));

      // Reset at row 2, then a normal relaunch.
      press(3'd0, "rst_arm");
      wait_row(2, 40, "rst_row2");
      clr_counts();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_load", 32'(bus.SHOOT_CTRL_Load_OutLow), 32'd1);
      check("rst_clear", 32'(bus.SHOOT_CTRL_Clear_OutLow), 32'd1);
      check("rst_data", 32'(bus.SHOOT_CTRL_Data_OutBus), 32'd0);
      check("rst_busy", 32'(bus.SHOOT_CTRL_Busy_OutHigh), 32'd0);
      check("rst_row", 32'(bus.SHOOT_CTRL_Row_OutBus), 32'd0);
      check("rst_tick_cnt", 32'(dut.u_tick.r_count), 32'd0);
      check("rst_strobes", 32'(n_load + n_clear), 32'd0);
      press(3'd3, "relaunch_arm");
      n = 0;
      while (bus.SHOOT_CTRL_Load_OutLow !== 1'b0 && n < 10) begin step(); n++; end
      check("relaunch_data", 32'(bus.SHOOT_CTRL_Data_OutBus), 32'h08);
      check("relaunch_row", 32'(bus.SHOOT_CTRL_Row_OutBus), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
